boreal_ledger_auditor: RTL and testbench

// - Downstream consumer of the append-only ledger: walks entries 0..count_in-1 over
//   the ledger public read port and re-verifies the dev hash chain.
// - Each entry is {prev_hash[63:0] in [255:192], payload[191:0]}. Entry i's

---
 rtl/boreal_ledger_auditor.sv | 185 ++++++++++++++++++
 tb/tb_boreal_ledger_auditor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_ledger_auditor.sv
// Walks ledger entries 0..count_in-1, re-verifies the FNV-1a style hash chain; 34 cycles per entry.
// Define LEDGER_AUDIT_CONTINUE_EN to keep walking past mismatches and count them on err_count.
module boreal_ledger_auditor #(
  parameter int DEPTH = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [31:0]  count_in,
  output logic         rd_req,
  output logic [9:0]   rd_addr,
  input  logic [255:0] rd_data,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         overflow,
  output logic [9:0]   fail_addr,
  output logic [63:0]  final_hash,
  output logic [31:0]  entries_checked
`ifdef LEDGER_AUDIT_CONTINUE_EN
  ,
  output logic [31:0]  err_count
`endif
);

  localparam logic [63:0] HASH_INIT  = 64'hCBF29CE484222325;
  localparam logic [63:0] HASH_PRIME = 64'h00000100000001B3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_CNT,
    S_REQ,
    S_CAPTURE,
    S_HASH,
    S_FINISH
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_count;
  logic [10:0]   r_index;
  logic [4:0]    r_byte;
  logic [255:0]  r_entry;
  logic [63:0]   r_hash;
  logic          r_pass;
  logic          r_overflow;
  logic [9:0]    r_fail_addr;
  logic [63:0]   r_final_hash;
  logic [31:0]   r_entries_checked;
`ifdef LEDGER_AUDIT_CONTINUE_EN
  logic [31:0]   r_err_count;
`endif

  logic          w_mismatch;
  logic [7:0]    w_byte;
  logic [63:0]   w_hash_step;
  logic [63:0]   w_hash_nxt;
  logic          w_last_byte;
  logic [10:0]   w_index_inc;
  logic          w_last_entry;
  logic          w_cnt_zero;
  logic          w_cnt_over;

  assign w_mismatch   = (rd_data[255:192] != r_hash);
  assign w_byte       = r_entry[{r_byte, 3'b000} +: 8];
  assign w_hash_step  = (r_hash ^ {56'h0, w_byte}) * HASH_PRIME;
  assign w_hash_nxt   = (r_state == S_HASH) ? w_hash_step : r_hash;
  assign w_last_byte  = (r_byte == 5'd31);
  assign w_index_inc  = r_index + 11'd1;
  assign w_last_entry = ({21'd0, w_index_inc} == r_count);
  assign w_cnt_zero   = (r_count == 32'd0);
  assign w_cnt_over   = (r_count > 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_CHK_CNT;
      S_CHK_CNT: w_state_nxt = (w_cnt_zero || w_cnt_over) ? S_FINISH : S_REQ;
      S_REQ:     w_state_nxt = S_CAPTURE;
`ifdef LEDGER_AUDIT_CONTINUE_EN
      S_CAPTURE: w_state_nxt = S_HASH;
`else
      S_CAPTURE: w_state_nxt = w_mismatch ? S_FINISH : S_HASH;
`endif
      S_HASH:    if (w_last_byte) w_state_nxt = w_last_entry ? S_FINISH : S_REQ;
      S_FINISH:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_req = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_CHK_CNT, S_CAPTURE, S_HASH: busy = 1'b1;
      S_REQ: begin
        busy   = 1'b1;
        rd_req = 1'b1;
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count           <= 32'd0;
      r_index           <= 11'd0;
      r_byte            <= 5'd0;
      r_entry           <= 256'd0;
      r_hash            <= HASH_INIT;
      r_pass            <= 1'b0;
      r_overflow        <= 1'b0;
      r_fail_addr       <= 10'd0;
      r_final_hash      <= 64'd0;
      r_entries_checked <= 32'd0;
`ifdef LEDGER_AUDIT_CONTINUE_EN
      r_err_count       <= 32'd0;
`endif
    end else begin
      // Snapshot the chain head on the way into FINISH so it is valid alongside done.
      if (r_state != S_FINISH && w_state_nxt == S_FINISH)
        r_final_hash <= w_hash_nxt;
      case (r_state)
        S_IDLE: if (start) begin
          r_count           <= count_in;
          r_index           <= 11'd0;
          r_byte            <= 5'd0;
          r_hash            <= HASH_INIT;
          r_pass            <= 1'b1;
          r_overflow        <= 1'b0;
          r_fail_addr       <= 10'd0;
          r_entries_checked <= 32'd0;
`ifdef LEDGER_AUDIT_CONTINUE_EN
          r_err_count       <= 32'd0;
`endif
        end
        S_CHK_CNT: if (w_cnt_over) begin
          r_overflow <= 1'b1;
          r_pass     <= 1'b0;
        end
        S_CAPTURE: begin
          r_entry <= rd_data;
          r_byte  <= 5'd0;
          if (w_mismatch) begin
            r_pass <= 1'b0;
`ifdef LEDGER_AUDIT_CONTINUE_EN
            if (r_err_count == 32'd0) r_fail_addr <= r_index[9:0];
            r_err_count <= r_err_count + 32'd1;
`else
            r_fail_addr <= r_index[9:0];
`endif
          end
        end
        S_HASH: begin
          r_hash <= w_hash_step;
          r_byte <= r_byte + 5'd1;
          if (w_last_byte) begin
            r_entries_checked <= r_entries_checked + 32'd1;
            r_index           <= w_index_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_addr         = r_index[9:0];
  assign pass            = r_pass;
  assign overflow        = r_overflow;
  assign fail_addr       = r_fail_addr;
  assign final_hash      = r_final_hash;
  assign entries_checked = r_entries_checked;
`ifdef LEDGER_AUDIT_CONTINUE_EN
  assign err_count       = r_err_count;
`endif

endmodule

// File: tb/tb_boreal_ledger_auditor.sv
// Scoreboard bench for boreal_ledger_auditor: directed audits with a small ledger memory model.
`timescale 1ns/1ps
module tb_boreal_ledger_auditor;

  localparam logic [63:0] HASH_INIT = 64'hCBF29CE484222325;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  count_in = 32'd0;
  logic         rd_req;
  logic [9:0]   rd_addr;
  logic [255:0] rd_data = '0;
  logic         busy, done, pass, overflow;
  logic [9:0]   fail_addr;
  logic [63:0]  final_hash;
  logic [31:0]  entries_checked;
`ifdef LEDGER_AUDIT_CONTINUE_EN
  logic [31:0]  err_count;
`endif

  always #5 clk = ~clk;

  boreal_ledger_auditor #(.DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count_in(count_in),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .overflow(overflow),
    .fail_addr(fail_addr), .final_hash(final_hash),
    .entries_checked(entries_checked)
`ifdef LEDGER_AUDIT_CONTINUE_EN
    , .err_count(err_count)
`endif
  );

  typedef struct {
    logic        pass;
    logic        overflow;
    logic [9:0]  fail_addr;
    logic [63:0] final_hash;
    logic [31:0] ec;
    logic [31:0] err;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [9:0]  addr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [255:0] ledger [0:7];
  logic [63:0] chain_h [0:2];
  exp_t        mon_e;
  logic [9:0]  mon_a;

  // Ledger read port: data returned the cycle after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_req) rd_data <= ledger[rd_addr[2:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] fnv(input logic [63:0] h_in, input logic [255:0] e);
    logic [63:0] h = h_in;
    for (int k = 0; k < 32; k++) begin
      h = h ^ {56'h0, e[8*k +: 8]};
      h = h * 64'h00000100000001B3;
    end
    return h;
  endfunction

  function automatic exp_t mk(input logic p, input logic ov, input logic [9:0] fa,
                              input logic [63:0] fh, input logic [31:0] ec,
                              input logic [31:0] err, input int lat);
    exp_t e;
    e.pass = p; e.overflow = ov; e.fail_addr = fa; e.final_hash = fh;
    e.ec = ec; e.err = err; e.lat = lat; e.start_cyc = 0;
    return e;
  endfunction

  task automatic build_chain(input logic corrupt);
    logic [191:0] pl [0:2];
    logic [63:0]  h = HASH_INIT;
    pl[0] = 192'd0;
    pl[1] = 192'd1;
    pl[2] = 192'd1 << 191;
    for (int i = 0; i < 8; i++) ledger[i] = '0;
    for (int i = 0; i < 3; i++) begin
      ledger[i]  = {h, pl[i]};
      h          = fnv(h, ledger[i]);
      chain_h[i] = h;
    end
    if (corrupt) ledger[1][192] = ~ledger[1][192];
  endtask

  task automatic launch(input logic [31:0] cnt, input exp_t e, input int naddr);
    exp_t ee = e;
    @(negedge clk);
    start = 1'b1;
    count_in = cnt;
    ee.start_cyc = cyc;
    exp_q.push_back(ee);
    for (int a = 0; a < naddr; a++) addr_q.push_back(10'(a));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    check("rd_addr_drained", 64'(addr_q.size()), 64'd0);
    addr_q.delete();
  endtask

  // Monitor: every strobe and every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rd_req) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_req_unexpected: got addr %0d required no read", rd_addr);
      end else begin
        mon_a = addr_q.pop_front();
        check("rd_addr", 64'(rd_addr), 64'(mon_a));
      end
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 required 0");
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
        check("busy_at_done", 64'(busy), 64'd0);
        check("pass", 64'(pass), 64'(mon_e.pass));
        check("overflow", 64'(overflow), 64'(mon_e.overflow));
        check("fail_addr", 64'(fail_addr), 64'(mon_e.fail_addr));
        check("final_hash", final_hash, mon_e.final_hash);
        check("entries_checked", 64'(entries_checked), 64'(mon_e.ec));
`ifdef LEDGER_AUDIT_CONTINUE_EN
        check("err_count", 64'(err_count), 64'(mon_e.err));
`endif
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rd_req"}, 64'(rd_req), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_fail_addr"}, 64'(fail_addr), 64'd0);
    check({tag, "_final_hash"}, final_hash, 64'd0);
    check({tag, "_entries"}, 64'(entries_checked), 64'd0);
`ifdef LEDGER_AUDIT_CONTINUE_EN
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
`endif
  endtask

  initial begin
    exp_t good3;
    logic [63:0] h;
    build_chain(1'b0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // T1: empty audit
    launch(32'd0, mk(1'b1, 1'b0, 10'd0, HASH_INIT, 32'd0, 32'd0, 2), 0);
    wait_done(20);

    // T2: three chained entries
    good3 = mk(1'b1, 1'b0, 10'd0, chain_h[2], 32'd3, 32'd0, 2 + 3*34);
    launch(32'd3, good3, 3);
    wait_done(200);

    // Single entry boundary
    launch(32'd1, mk(1'b1, 1'b0, 10'd0, chain_h[0], 32'd1, 32'd0, 2 + 34), 1);
    wait_done(100);

    // T3: entry 1 prev_hash corrupted
    build_chain(1'b1);
`ifdef LEDGER_AUDIT_CONTINUE_EN
    h = HASH_INIT;
    for (int i = 0; i < 3; i++) h = fnv(h, ledger[i]);
    launch(32'd3, mk(1'b0, 1'b0, 10'd1, h, 32'd3, 32'd2, 2 + 3*34), 3);
`else
    h = chain_h[0];
    launch(32'd3, mk(1'b0, 1'b0, 10'd1, h, 32'd1, 32'd0, 2 + 34 + 2), 2);
`endif
    wait_done(200);
    build_chain(1'b0);

    // T4: overflow, no reads
    launch(32'd1025, mk(1'b0, 1'b1, 10'd0, HASH_INIT, 32'd0, 32'd0, 2), 0);
    wait_done(20);
    launch(32'hFFFF_FFFF, mk(1'b0, 1'b1, 10'd0, HASH_INIT, 32'd0, 32'd0, 2), 0);
    wait_done(20);

    // T5: reset during HASH of entry 1, then rerun T2
    launch(32'd3, good3, 3);
    repeat (43) @(negedge clk);
    check("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    launch(32'd3, good3, 3);
    wait_done(200);

    // T6: second start while busy and count_in change are ignored
    launch(32'd3, good3, 3);
    repeat (5) @(negedge clk);
    start = 1'b1;
    count_in = 32'd0;
    @(negedge clk);
    start = 1'b0;
    count_in = 32'd7;
    wait_done(200);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
